// File: rtl/simmem_resp_bank.sv
// Response bank for the simulated memory controller: reserves slots, stores AXI
// response payloads and hands them out in per-ID order once released.
module simmem_resp_bank #(
    parameter  int IdWidth       = 2,
    parameter  int TotalCapacity = 8,
    parameter  int DataWidth     = 8,
    localparam int NumIds        = 2 ** IdWidth,
    localparam int AddrWidth     = $clog2(TotalCapacity)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic [IdWidth-1:0]       res_req_id_i,
    input  logic                     res_req_valid_i,
    output logic                     res_req_ready_o,
    output logic [AddrWidth-1:0]     res_addr_o,

    input  logic [IdWidth-1:0]       in_id_i,
    input  logic [DataWidth-1:0]     in_data_i,
    input  logic                     in_data_valid_i,
    output logic                     in_data_ready_o,

    input  logic [TotalCapacity-1:0] release_en_i,
    output logic [TotalCapacity-1:0] released_addr_onehot_o,

    output logic [IdWidth-1:0]       out_id_o,
    output logic [DataWidth-1:0]     out_data_o,
    output logic                     out_data_valid_o,
    input  logic                     out_data_ready_i
);

    typedef enum logic [1:0] {SlotFree, SlotReserved, SlotFilled} slot_state_e;

    slot_state_e          state_q [TotalCapacity];
    slot_state_e          state_d [TotalCapacity];
    logic [IdWidth-1:0]   id_q    [TotalCapacity];
    logic [AddrWidth-1:0] seq_q   [TotalCapacity];
    logic [DataWidth-1:0] data_q  [TotalCapacity];

    logic [AddrWidth-1:0] res_cnt_q  [NumIds];
    logic [AddrWidth-1:0] res_cnt_d  [NumIds];
    logic [AddrWidth-1:0] fill_cnt_q [NumIds];
    logic [AddrWidth-1:0] fill_cnt_d [NumIds];
    logic [AddrWidth-1:0] out_cnt_q  [NumIds];
    logic [AddrWidth-1:0] out_cnt_d  [NumIds];

    logic                 out_valid_q, out_valid_d;
    logic [IdWidth-1:0]   out_id_q, out_id_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;

    logic [TotalCapacity-1:0] free_vec, fill_match, eligible;
    logic [AddrWidth-1:0]     fill_addr, rel_addr;
    logic                     res_hs, fill_hs, load;

    function automatic logic [AddrWidth-1:0] lowest_set(input logic [TotalCapacity-1:0] v);
        lowest_set = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = AddrWidth'(i);
        end
    endfunction

    // Per-ID sequence numbers are unique, so at most one slot matches each head.
    always_comb begin
        free_vec   = '0;
        fill_match = '0;
        eligible   = '0;
        for (int i = 0; i < TotalCapacity; i++) begin
            free_vec[i]   = (state_q[i] == SlotFree);
            fill_match[i] = (state_q[i] == SlotReserved) && (id_q[i] == in_id_i) &&
                            (seq_q[i] == fill_cnt_q[in_id_i]);
            eligible[i]   = (state_q[i] == SlotFilled) && release_en_i[i] &&
                            (seq_q[i] == out_cnt_q[id_q[i]]);
        end
    end

    assign res_req_ready_o = |free_vec;
    assign res_addr_o      = lowest_set(free_vec);
    assign in_data_ready_o = |fill_match;
    assign fill_addr       = lowest_set(fill_match);
    assign rel_addr        = lowest_set(eligible);

    assign res_hs  = res_req_valid_i && res_req_ready_o;
    assign fill_hs = in_data_valid_i && in_data_ready_o;
    assign load    = (|eligible) && (!out_valid_q || out_data_ready_i);

    assign released_addr_onehot_o = load ? (TotalCapacity'(1) << rel_addr) : '0;

    // The three transitions act on slots in distinct states, so they never collide.
    always_comb begin
        for (int i = 0; i < TotalCapacity; i++) state_d[i] = state_q[i];
        res_cnt_d  = res_cnt_q;
        fill_cnt_d = fill_cnt_q;
        out_cnt_d  = out_cnt_q;
        if (res_hs) begin
            state_d[res_addr_o]     = SlotReserved;
            res_cnt_d[res_req_id_i] = res_cnt_q[res_req_id_i] + AddrWidth'(1);
        end
        if (fill_hs) begin
            state_d[fill_addr]    = SlotFilled;
            fill_cnt_d[in_id_i]   = fill_cnt_q[in_id_i] + AddrWidth'(1);
        end
        if (load) begin
            state_d[rel_addr]           = SlotFree;
            out_cnt_d[id_q[rel_addr]]   = out_cnt_q[id_q[rel_addr]] + AddrWidth'(1);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_id_d    = id_q[rel_addr];
            out_data_d  = data_q[rel_addr];
        end else if (out_valid_q && out_data_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TotalCapacity; i++) begin
                state_q[i] <= SlotFree;
                id_q[i]    <= '0;
                seq_q[i]   <= '0;
                data_q[i]  <= '0;
            end
            for (int j = 0; j < NumIds; j++) begin
                res_cnt_q[j]  <= '0;
                fill_cnt_q[j] <= '0;
                out_cnt_q[j]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < TotalCapacity; i++) state_q[i] <= state_d[i];
            res_cnt_q  <= res_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            out_cnt_q  <= out_cnt_d;
            if (res_hs) begin
                id_q[res_addr_o]  <= res_req_id_i;
                seq_q[res_addr_o] <= res_cnt_q[res_req_id_i];
            end
            if (fill_hs) data_q[fill_addr] <= in_data_i;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data_valid_o = out_valid_q;
    assign out_id_o         = out_id_q;
    assign out_data_o       = out_data_q;

endmodule

// File: tb/tb_simmem_resp_bank.sv
// Scoreboard bench for simmem_resp_bank: expected responses are queued as they
// become releasable and matched against every output handshake.
module tb_simmem_resp_bank;

    localparam int IdW = 2;
    localparam int Cap = 8;
    localparam int DW  = 8;
    localparam int AW  = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [IdW-1:0] res_req_id_i = '0;
    logic          res_req_valid_i = 1'b0;
    logic          res_req_ready_o;
    logic [AW-1:0] res_addr_o;
    logic [IdW-1:0] in_id_i = '0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_data_valid_i = 1'b0;
    logic          in_data_ready_o;
    logic [Cap-1:0] release_en_i = '0;
    logic [Cap-1:0] released_addr_onehot_o;
    logic [IdW-1:0] out_id_o;
    logic [DW-1:0] out_data_o;
    logic          out_data_valid_o;
    logic          out_data_ready_i = 1'b1;

    simmem_resp_bank #(.IdWidth(IdW), .TotalCapacity(Cap), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .res_req_id_i(res_req_id_i), .res_req_valid_i(res_req_valid_i),
        .res_req_ready_o(res_req_ready_o), .res_addr_o(res_addr_o),
        .in_id_i(in_id_i), .in_data_i(in_data_i), .in_data_valid_i(in_data_valid_i),
        .in_data_ready_o(in_data_ready_o),
        .release_en_i(release_en_i), .released_addr_onehot_o(released_addr_onehot_o),
        .out_id_o(out_id_o), .out_data_o(out_data_o), .out_data_valid_o(out_data_valid_o),
        .out_data_ready_i(out_data_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;
    int n_pulse = 0;
    logic [IdW+DW-1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change only on negedge; the monitor samples mid-phase before the next posedge.
    always begin
        @(negedge clk_i);
        #3;
        if (rst_ni) begin
            if (released_addr_onehot_o != '0) begin
                n_pulse++;
                chk("rel_onehot", 32'($countones(released_addr_onehot_o)), 1);
            end
            if (out_data_valid_o && out_data_ready_i) begin
                n_out++;
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("out_resp", 32'({out_id_o, out_data_o}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_data_valid_o), 0);
        chk({tag, "_id"}, 32'(out_id_o), 0);
        chk({tag, "_data"}, 32'(out_data_o), 0);
        chk({tag, "_rel"}, 32'(released_addr_onehot_o), 0);
        chk({tag, "_resrdy"}, 32'(res_req_ready_o), 1);
        chk({tag, "_resaddr"}, 32'(res_addr_o), 0);
        chk({tag, "_inrdy"}, 32'(in_data_ready_o), 0);
    endtask

    task automatic reserve(input int id, input int exp_addr);
        res_req_id_i = IdW'(id);
        res_req_valid_i = 1'b1;
        #1;
        chk("res_ready", 32'(res_req_ready_o), 1);
        chk("res_addr", 32'(res_addr_o), 32'(exp_addr));
        @(negedge clk_i);
        res_req_valid_i = 1'b0;
    endtask

    task automatic fill(input int id, input int data);
        in_id_i = IdW'(id);
        in_data_i = DW'(data);
        in_data_valid_i = 1'b1;
        #1;
        chk("fill_ready", 32'(in_data_ready_o), 1);
        @(negedge clk_i);
        in_data_valid_i = 1'b0;
    endtask

    task automatic expect_out(input int id, input int data);
        sb.push_back({IdW'(id), DW'(data)});
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk_i);
        end
        chk("drain", 32'(sb.size()), 0);
    endtask

    int p0, o0;

    initial begin
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_reset_outputs("post_rst");
        @(negedge clk_i);

        // Three IDs, fill out of order, enable all afterwards -> slot order.
        p0 = n_pulse;
        reserve(0, 0); reserve(1, 1); reserve(2, 2);
        fill(2, 'hC2); fill(0, 'hC0); fill(1, 'hC1);
        expect_out(0, 'hC0); expect_out(1, 'hC1); expect_out(2, 'hC2);
        release_en_i = '1;
        drain(10);
        chk("t1_pulses", 32'(n_pulse - p0), 3);
        release_en_i = '0;
        @(negedge clk_i);

        // Same ID three times; releasing only the tail must not bypass the head.
        p0 = n_pulse;
        reserve(1, 0); reserve(1, 1); reserve(1, 2);
        fill(1, 'hA0); fill(1, 'hA1); fill(1, 'hA2);
        release_en_i = 8'b0000_0100;
        repeat (4) @(negedge clk_i);
        #1;
        chk("t2_blocked_valid", 32'(out_data_valid_o), 0);
        chk("t2_blocked_pulses", 32'(n_pulse - p0), 0);
        expect_out(1, 'hA0); expect_out(1, 'hA1); expect_out(1, 'hA2);
        release_en_i = 8'b0000_0111;
        drain(10);
        release_en_i = '0;
        @(negedge clk_i);

        // Fill with no reservation for ID 3 is never accepted.
        in_id_i = 2'd3; in_data_i = 8'h33; in_data_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("nores_ready", 32'(in_data_ready_o), 0);
            @(negedge clk_i);
        end
        in_data_valid_i = 1'b0;
        #1;
        chk("nores_resaddr", 32'(res_addr_o), 0);
        @(negedge clk_i);

        // Fill the bank, then free slot 4 (sole ID-3 entry).
        reserve(0, 0); reserve(0, 1); reserve(0, 2); reserve(0, 3);
        reserve(3, 4); reserve(2, 5); reserve(2, 6); reserve(2, 7);
        #1;
        chk("full_ready", 32'(res_req_ready_o), 0);
        @(negedge clk_i);
        fill(0, 'h40); fill(0, 'h41); fill(0, 'h42); fill(0, 'h43);
        fill(3, 'h44); fill(2, 'h45); fill(2, 'h46); fill(2, 'h47);
        expect_out(3, 'h44);
        release_en_i = 8'b0001_0000;
        #1;
        chk("rel4_pulse", 32'(released_addr_onehot_o), 32'h10);
        chk("rel4_still_full", 32'(res_req_ready_o), 0);
        @(negedge clk_i);
        release_en_i = '0;
        #1;
        chk("rel4_ready", 32'(res_req_ready_o), 1);
        chk("rel4_addr", 32'(res_addr_o), 4);
        drain(5);
        @(negedge clk_i);

        // Backpressure: output held stable, single pulse, then one per cycle.
        expect_out(0, 'h40); expect_out(0, 'h41); expect_out(0, 'h42); expect_out(0, 'h43);
        expect_out(2, 'h45); expect_out(2, 'h46); expect_out(2, 'h47);
        out_data_ready_i = 1'b0;
        p0 = n_pulse;
        release_en_i = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            #1;
            chk("stall_valid", 32'(out_data_valid_o), 1);
            chk("stall_id", 32'(out_id_o), 0);
            chk("stall_data", 32'(out_data_o), 32'h40);
        end
        chk("stall_pulses", 32'(n_pulse - p0), 1);
        @(negedge clk_i);
        out_data_ready_i = 1'b1;
        o0 = n_out;
        repeat (7) @(negedge clk_i);
        #4;
        chk("b2b_count", 32'(n_out - o0), 7);
        drain(3);
        release_en_i = '0;
        @(negedge clk_i);

        // Wrap the ID-0 counters several times.
        release_en_i = '1;
        for (int r = 0; r < 20; r++) begin
            reserve(0, 0); reserve(0, 1);
            fill(0, 'h80 + 2 * r); fill(0, 'h81 + 2 * r);
            expect_out(0, 'h80 + 2 * r); expect_out(0, 'h81 + 2 * r);
            drain(8);
        end

        // Reset in the middle of traffic.
        out_data_ready_i = 1'b0;
        reserve(0, 0); reserve(0, 1); reserve(0, 2);
        fill(0, 'h11); fill(0, 'h22);
        @(negedge clk_i);
        #1;
        chk("pre_rst_valid", 32'(out_data_valid_o), 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        out_data_ready_i = 1'b1;
        @(negedge clk_i);
        reserve(0, 0);
        fill(0, 'h5A);
        expect_out(0, 'h5A);
        drain(5);
        release_en_i = '0;
        repeat (2) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
